cpu_step_controller: RTL and testbench

Clock-enable and reset sequencer that sits directly upstream of the single-cycle RISC-V FPGA top level. It turns raw board pushbuttons and a mode switch into a one-cycle `cpu_tick` qualifier, so the processor advances either one instruction per button press or at a divided free-running rate. It also produces a stretched, debounced `cpu_reset` and a retired-tick counter for the HEX/debug path. The whole block runs on the board clock `clk`; `cpu_tick` gates the PC, register-file, data-memory and display-register updates.

---
 rtl/cpu_step_controller.sv | 152 +++++++++++++++
 tb/tb_cpu_step_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_controller.sv
// Turns raw buttons and the run switch into a one-cycle cpu_tick, a stretched cpu_reset and a tick counter.
// Step ticks land 1 cycle after a debounced press; run ticks come every RUN_DIV cycles; no backpressure.
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 12500000,
    parameter int POR_CYCLES      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_step_n,
    input  logic        btn_rst_n,
    input  logic        sw_run,
    output logic        cpu_tick,
    output logic        cpu_reset,
    output logic        running,
    output logic [31:0] tick_count
);
    localparam int DBW  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIVW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam int PORW = $clog2(POR_CYCLES + 1);
    localparam logic [DBW-1:0]  DB_MAX   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIVW-1:0] DIV_MAX  = DIVW'(RUN_DIV - 1);
    localparam logic [PORW-1:0] POR_INIT = PORW'(POR_CYCLES);

    typedef enum logic [1:0] {SEQ_RESET, STEP, RUN} state_t;

    logic            step_s1, step_s2, rst_s1, rst_s2, run_s1, run_s2;
    logic            step_lvl, step_lvl_d, rst_lvl, rst_lvl_d;
    logic [DBW-1:0]  step_cnt, rst_cnt;
    logic            step_press, rst_press;
    logic [PORW-1:0] por_cnt;
    state_t          state, state_nxt;
    logic [DIVW-1:0] div_cnt;
    logic            run_tick, step_pend;
    logic [31:0]     tick_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            {step_s1, step_s2, rst_s1, rst_s2, run_s1, run_s2} <= 6'b111100;
        end else begin
            step_s1 <= btn_step_n;
            step_s2 <= step_s1;
            rst_s1  <= btn_rst_n;
            rst_s2  <= rst_s1;
            run_s1  <= sw_run;
            run_s2  <= run_s1;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_lvl   <= 1'b1;
            step_lvl_d <= 1'b1;
            step_cnt   <= '0;
        end else begin
            step_lvl_d <= step_lvl;
            if (step_s2 != step_lvl) begin
                if (step_cnt == DB_MAX) begin
                    step_lvl <= step_s2;
                    step_cnt <= '0;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end else begin
                step_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rst_lvl   <= 1'b1;
            rst_lvl_d <= 1'b1;
            rst_cnt   <= '0;
        end else begin
            rst_lvl_d <= rst_lvl;
            if (rst_s2 != rst_lvl) begin
                if (rst_cnt == DB_MAX) begin
                    rst_lvl <= rst_s2;
                    rst_cnt <= '0;
                end else begin
                    rst_cnt <= rst_cnt + 1'b1;
                end
            end else begin
                rst_cnt <= '0;
            end
        end
    end

    assign step_press = step_lvl_d & ~step_lvl;
    assign rst_press  = rst_lvl_d & ~rst_lvl;

    always_ff @(posedge clk) begin
        if (reset || rst_press) begin
            por_cnt <= POR_INIT;
        end else if (por_cnt != '0) begin
            por_cnt <= por_cnt - 1'b1;
        end
    end

    assign cpu_reset = reset | (por_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEQ_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEQ_RESET: state_nxt = run_s2 ? RUN : STEP;
            STEP:      if (run_s2) state_nxt = RUN;
            RUN:       if (!run_s2) state_nxt = STEP;
            default:   state_nxt = SEQ_RESET;
        endcase
        if (cpu_reset) begin
            state_nxt = SEQ_RESET;
        end
        // A run tick only fires if RUN is also held next cycle, so the exit cycle never ticks.
        run_tick = (state == RUN) && (state_nxt == RUN) && (div_cnt == DIV_MAX);
        cpu_tick = !cpu_reset && (state != SEQ_RESET) && (step_pend || run_tick);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            step_pend <= 1'b0;
        end else begin
            if ((state == RUN) && (state_nxt == RUN)) begin
                div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end
            step_pend <= (state == STEP) && step_press && !rst_press && !cpu_reset;
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_reset) begin
            tick_cnt <= '0;
        end else if (cpu_tick) begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    assign tick_count = cpu_reset ? 32'd0 : tick_cnt;
    assign running    = (state == RUN);
endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller with small debounce, divider and POR parameters.
module tb_cpu_step_controller;
    logic        clk = 1'b0;
    logic        reset, btn_step_n, btn_rst_n, sw_run;
    logic        cpu_tick, cpu_reset, running;
    logic [31:0] tick_count;
    int          n_checks = 0;
    int          n_pass = 0;

    cpu_step_controller #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV(5),
        .POR_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_step_n(btn_step_n),
        .btn_rst_n(btn_rst_n),
        .sw_run(sw_run),
        .cpu_tick(cpu_tick),
        .cpu_reset(cpu_reset),
        .running(running),
        .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    task cyc;
        @(posedge clk);
        #1;
    endtask

    task do_reset;
        reset = 1'b1;
        sw_run = 1'b0;
        btn_step_n = 1'b1;
        btn_rst_n = 1'b1;
        cyc;
        cyc;
        reset = 1'b0;
        repeat (5) cyc;
    endtask

    task test_reset;
        int bad;
        reset = 1'b1;
        btn_step_n = 1'b1;
        btn_rst_n = 1'b1;
        sw_run = 1'b0;
        cyc;
        cyc;
        n_checks++; if (cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset got %b expected 1", cpu_reset); else n_pass++;
        n_checks++; if (cpu_tick !== 1'b0) $display("FAIL rst_cpu_tick got %b expected 0", cpu_tick); else n_pass++;
        n_checks++; if (running !== 1'b0) $display("FAIL rst_running got %b expected 0", running); else n_pass++;
        n_checks++; if (tick_count !== 32'd0) $display("FAIL rst_tick_count got %0h expected 0", tick_count); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (cpu_reset !== 1'b1) $display("FAIL por_cycle0 got %b expected 1", cpu_reset); else n_pass++;
        for (int i = 1; i < 3; i++) begin
            cyc;
            n_checks++; if (cpu_reset !== 1'b1) $display("FAIL por_cycle%0d got %b expected 1", i, cpu_reset); else n_pass++;
        end
        cyc;
        n_checks++; if (cpu_reset !== 1'b0) $display("FAIL por_end got %b expected 0", cpu_reset); else n_pass++;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cyc;
            if (cpu_tick !== 1'b0 || running !== 1'b0 || tick_count !== 32'd0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL idle_after_reset got %0d bad cycles expected 0", bad); else n_pass++;
    endtask

    task test_step_latency;
        int lat, extra;
        btn_step_n = 1'b0;
        lat = 0;
        while (cpu_tick !== 1'b1 && lat < 20) begin
            cyc;
            lat++;
        end
        n_checks++; if (lat !== 7) $display("FAIL step_latency got %0d expected 7", lat); else n_pass++;
        cyc;
        n_checks++; if (cpu_tick !== 1'b0) $display("FAIL step_pulse_width got %b expected 0", cpu_tick); else n_pass++;
        n_checks++; if (tick_count !== 32'd1) $display("FAIL step_count got %0d expected 1", tick_count); else n_pass++;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            cyc;
            if (cpu_tick === 1'b1) extra++;
        end
        btn_step_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc;
            if (cpu_tick === 1'b1) extra++;
        end
        n_checks++; if (extra !== 0) $display("FAIL step_hold_release got %0d ticks expected 0", extra); else n_pass++;
    endtask

    task test_bounce;
        int ticks, first;
        ticks = 0;
        first = -1;
        btn_step_n = 1'b0;
        cyc; if (cpu_tick === 1'b1) ticks++;
        cyc; if (cpu_tick === 1'b1) ticks++;
        btn_step_n = 1'b1;
        cyc; if (cpu_tick === 1'b1) ticks++;
        btn_step_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc;
            if (cpu_tick === 1'b1) begin
                ticks++;
                if (first < 0) first = k;
            end
        end
        btn_step_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            cyc;
            if (cpu_tick === 1'b1) ticks++;
        end
        n_checks++; if (first !== 7) $display("FAIL bounce_latency got %0d expected 7", first); else n_pass++;
        n_checks++; if (ticks !== 1) $display("FAIL bounce_ticks got %0d expected 1", ticks); else n_pass++;
        n_checks++; if (tick_count !== 32'd2) $display("FAIL bounce_count got %0d expected 2", tick_count); else n_pass++;
    endtask

    task test_run_mode;
        int lat, ticks, first;
        do_reset;
        sw_run = 1'b1;
        lat = 0;
        while (running !== 1'b1 && lat < 20) begin
            cyc;
            lat++;
        end
        n_checks++; if (lat !== 3) $display("FAIL run_entry_latency got %0d expected 3", lat); else n_pass++;
        ticks = 0;
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) btn_step_n = 1'b0;
            if (k == 20) btn_step_n = 1'b1;
            cyc;
            if (cpu_tick === 1'b1) begin
                ticks++;
                if (first < 0) first = k;
            end
        end
        n_checks++; if (first !== 4) $display("FAIL run_first_tick got %0d expected 4", first); else n_pass++;
        n_checks++; if (ticks !== 8) $display("FAIL run_ticks got %0d expected 8", ticks); else n_pass++;
        n_checks++; if (tick_count !== 32'd8) $display("FAIL run_count got %0d expected 8", tick_count); else n_pass++;
        n_checks++; if (running !== 1'b1) $display("FAIL run_running got %b expected 1", running); else n_pass++;
    endtask

    task test_mode_change;
        int ticks, lat, first;
        ticks = 0;
        cyc;
        sw_run = 1'b0;
        cyc; if (cpu_tick === 1'b1) ticks++;
        cyc; if (cpu_tick === 1'b1) ticks++;
        n_checks++; if (running !== 1'b1) $display("FAIL mode_exit_cycle got %b expected 1", running); else n_pass++;
        cyc; if (cpu_tick === 1'b1) ticks++;
        n_checks++; if (running !== 1'b0) $display("FAIL mode_step_state got %b expected 0", running); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            cyc;
            if (cpu_tick === 1'b1) ticks++;
        end
        n_checks++; if (ticks !== 0) $display("FAIL mode_exit_ticks got %0d expected 0", ticks); else n_pass++;
        n_checks++; if (tick_count !== 32'd8) $display("FAIL mode_count_hold got %0d expected 8", tick_count); else n_pass++;
        sw_run = 1'b1;
        lat = 0;
        while (running !== 1'b1 && lat < 20) begin
            cyc;
            lat++;
        end
        n_checks++; if (lat !== 3) $display("FAIL mode_reentry_latency got %0d expected 3", lat); else n_pass++;
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            cyc;
            if (cpu_tick === 1'b1 && first < 0) first = k;
        end
        n_checks++; if (first !== 4) $display("FAIL mode_reentry_tick got %0d expected 4", first); else n_pass++;
        n_checks++; if (tick_count !== 32'd10) $display("FAIL mode_reentry_count got %0d expected 10", tick_count); else n_pass++;
    endtask

    task test_cpu_reset_button;
        int lat, bad, first;
        do_reset;
        sw_run = 1'b1;
        lat = 0;
        while (tick_count !== 32'd6 && lat < 100) begin
            cyc;
            lat++;
        end
        n_checks++; if (tick_count !== 32'd6) $display("FAIL btn_rst_setup got %0d expected 6", tick_count); else n_pass++;
        btn_rst_n = 1'b0;
        lat = 0;
        while (cpu_reset !== 1'b1 && lat < 20) begin
            cyc;
            lat++;
        end
        n_checks++; if (lat !== 7) $display("FAIL btn_rst_latency got %0d expected 7", lat); else n_pass++;
        n_checks++; if (tick_count !== 32'd0) $display("FAIL btn_rst_count_clear got %0d expected 0", tick_count); else n_pass++;
        bad = 0;
        if (cpu_tick !== 1'b0) bad++;
        cyc;
        if (cpu_reset !== 1'b1 || cpu_tick !== 1'b0) bad++;
        force dut.rst_press = 1'b1;
        cyc;
        release dut.rst_press;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (cpu_reset !== 1'b1 || cpu_tick !== 1'b0 || tick_count !== 32'd0) bad++;
            cyc;
        end
        n_checks++; if (bad !== 0) $display("FAIL btn_rst_stretch got %0d bad cycles expected 0", bad); else n_pass++;
        n_checks++; if (cpu_reset !== 1'b0) $display("FAIL btn_rst_extend_end got %b expected 0", cpu_reset); else n_pass++;
        btn_rst_n = 1'b1;
        lat = 0;
        while (running !== 1'b1 && lat < 20) begin
            cyc;
            lat++;
        end
        n_checks++; if (lat !== 1) $display("FAIL btn_rst_resume got %0d expected 1", lat); else n_pass++;
        first = -1;
        for (int k = 1; k <= 5; k++) begin
            cyc;
            if (cpu_tick === 1'b1 && first < 0) first = k;
        end
        n_checks++; if (first !== 4) $display("FAIL btn_rst_first_tick got %0d expected 4", first); else n_pass++;
        n_checks++; if (tick_count !== 32'd1) $display("FAIL btn_rst_recount got %0d expected 1", tick_count); else n_pass++;
    endtask

    task test_wrap;
        int lat;
        do_reset;
        force dut.tick_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.tick_cnt;
        #1;
        n_checks++; if (tick_count !== 32'hFFFF_FFFF) $display("FAIL wrap_preset got %0h expected ffffffff", tick_count); else n_pass++;
        btn_step_n = 1'b0;
        lat = 0;
        while (cpu_tick !== 1'b1 && lat < 20) begin
            cyc;
            lat++;
        end
        n_checks++; if (lat !== 7) $display("FAIL wrap_tick_latency got %0d expected 7", lat); else n_pass++;
        cyc;
        n_checks++; if (cpu_tick !== 1'b0) $display("FAIL wrap_pulse_width got %b expected 0", cpu_tick); else n_pass++;
        n_checks++; if (tick_count !== 32'd0) $display("FAIL wrap_count got %0h expected 0", tick_count); else n_pass++;
        btn_step_n = 1'b1;
        repeat (8) cyc;
    endtask

    initial begin
        test_reset;
        test_step_latency;
        test_bounce;
        test_run_mode;
        test_mode_change;
        test_cpu_reset_button;
        test_wrap;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
